pl_bypass_regfile: RTL and testbench
====================================

Name: pl_bypass_regfile

Overview:
- Parametrised register file for the pipelined core with an integrated bypass network and hazard control.
- Tracks destination tags for the EX and WB stages internally and supplies fully forwarded operands to the ID/EX boundary.
- Detects load-use hazards and raises a stall; accepts a flush that kills the instruction in ID.
- Sits between the ID stage, the EX unit and the data memory read port.
- Replaces the fixed 16-bit regfile and the equality-only forwarding unit.

Parameters:
DATA_W, 16, register and operand width in bits
NREG, 16, number of architectural registers (power of two, >=2); AW = clog2(NREG) is derived locally

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  instruction in ID is valid
id_rs1  input  AW  source register 1 index
id_rs2  input  AW  source register 2 index
id_rs1_used  input  1  ID instruction reads rs1
id_rs2_used  input  1  ID instruction reads rs2
id_rd  input  AW  ID destination index
id_rd_wr  input  1  ID instruction writes rd
id_is_load  input  1  ID instruction is a load
flush  input  1  kill ID instruction (taken branch/jump)
ex_result  input  DATA_W  EX-stage ALU result for the instruction currently in EX
dmem_rdata  input  DATA_W  synchronous data-memory read data, valid in the WB cycle of a load
rs1_data  output  DATA_W  forwarded rs1 operand (combinational)
rs2_data  output  DATA_W  forwarded rs2 operand (combinational)
stall  output  1  hold PC and IF/ID; ID instruction not accepted this cycle
wb_wr  output  1  register write occurring this cycle
wb_rd  output  AW  register written this cycle
wb_wdata  output  DATA_W  data written this cycle

Behaviour:
- Reset (async, rst_n=0): all NREG registers = 0; EX and WB tags invalid; wb_alu_q = 0.
  - Consequences: wb_wr=0, wb_rd=0, wb_wdata=0, stall=0.
  - rs1_data/rs2_data follow the RF, i.e. 0.
  - Reset mid-operation discards all in-flight tags immediately.
- EX tag {vld, rd, wr, load} update each edge:
  - Loads id tag when id_valid & !stall & !flush.
  - Otherwise loads a bubble (vld=0).
- WB tag update each edge:
  - Loads the EX tag unconditionally.
  - wb_alu_q <= ex_result.
- wb_wr = wb_vld & wb_wr_tag.
- wb_wdata = wb_load ? dmem_rdata : wb_alu_q.
- Register write happens at the rising edge when wb_wr=1: reg[wb_rd] <= wb_wdata.
- Operand select, per source, first match wins:
  1. EX hit: ex_vld & ex_wr & !ex_load & ex_rd==rs -> ex_result.
  2. WB hit: wb_wr & wb_rd==rs -> wb_wdata. This also covers write-and-read of the same register in the same cycle.
  3. Otherwise reg[rs].
- Youngest producer wins when EX and WB target the same register.
- stall = id_valid & !flush & ex_vld & ex_wr & ex_load & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
  - Exactly one bubble per load-use; after one stall cycle the load is in WB and forwards dmem_rdata.
  - Unused sources never cause a stall.
- flush has priority over stall: stall is forced to 0 and a bubble enters EX.
- Back-to-back writes to the same rd: each writes in order; the last one wins.
- Latency:
  - Operand outputs are combinational, 0 cycles.
  - The result of the instruction accepted in cycle N is architecturally visible in the RF after edge N+2.

Optional Feature:
- Macro: PL_BYPASS_ZERO_REG_EN
- Defined:
  - Register 0 always reads 0.
  - Writes to index 0 are dropped: wb_wr forced to 0 when wb_rd==0.
  - Index 0 never matches EX/WB forwarding and never causes a stall.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset then read all indices with no writes -> rs1_data=rs2_data=0, stall=0, wb_wr=0.
- Producer r3 (ex_result=16'h1234), then consumer r3 the next cycle -> rs1_data=16'h1234 from EX path, no stall.
- Two-instruction gap -> WB path value 16'h1234.
- Load r5 (dmem_rdata=16'hBEEF in WB), then consumer r5 -> stall=1 for exactly one cycle, then rs2_data=16'hBEEF.
- Same load-use pattern with id_rs2_used=0 -> no stall.
- Writes r7=16'h0001 then r7=16'h0002 in consecutive cycles, consumer in the cycle after -> EX/WB priority yields 16'h0002; RF holds 16'h0002 two edges later.
- Load-use with flush=1 in the same cycle -> stall=0; the next EX tag is a bubble, and wb_wr=0 two cycles later.
- With PL_BYPASS_ZERO_REG_EN: write r0=16'hFFFF -> wb_wr=0; reading r0 returns 0 on all paths.
- Without the macro: the same sequence reads back 16'hFFFF.

Source files
------------

// File: rtl/pl_bypass_regfile.sv
// Pipelined register file with EX/WB bypass network and load-use hazard control.
// Optional macro PL_BYPASS_ZERO_REG_EN hardwires register 0 to zero.
module pl_bypass_regfile #(
    parameter int DATA_W = 16,
    parameter int NREG   = 16,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [AW-1:0]     id_rs1,
    input  logic [AW-1:0]     id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [AW-1:0]     id_rd,
    input  logic              id_rd_wr,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              stall,
    output logic              wb_wr,
    output logic [AW-1:0]     wb_rd,
    output logic [DATA_W-1:0] wb_wdata
);

`ifdef PL_BYPASS_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [DATA_W-1:0] rf [NREG];

    logic              ex_vld;
    logic [AW-1:0]     ex_rd;
    logic              ex_wr;
    logic              ex_load;

    logic              wb_vld;
    logic [AW-1:0]     wb_rd_q;
    logic              wb_wr_tag;
    logic              wb_load;
    logic [DATA_W-1:0] wb_alu_q;

    logic              ex_rd_nz;
    logic              wb_rd_nz;
    logic              ex_fwd;
    logic              rs1_ld_hit;
    logic              rs2_ld_hit;
    logic [AW-1:0]     src [2];
    logic [DATA_W-1:0] op  [2];

    assign ex_rd_nz = !ZERO_REG || (ex_rd != '0);
    assign wb_rd_nz = !ZERO_REG || (wb_rd_q != '0);

    assign wb_wr    = wb_vld & wb_wr_tag & wb_rd_nz;
    assign wb_rd    = wb_rd_q;
    assign wb_wdata = wb_load ? dmem_rdata : wb_alu_q;

    // Loads in EX cannot forward; their data only exists once in WB.
    assign ex_fwd = ex_vld & ex_wr & !ex_load & ex_rd_nz;

    assign rs1_ld_hit = id_rs1_used & (id_rs1 == ex_rd);
    assign rs2_ld_hit = id_rs2_used & (id_rs2 == ex_rd);
    assign stall = id_valid & !flush & ex_vld & ex_wr & ex_load & ex_rd_nz
                 & (rs1_ld_hit | rs2_ld_hit);

    assign src[0] = id_rs1;
    assign src[1] = id_rs2;

    // Later assignments take priority: EX (youngest) over WB over the array.
    always_comb begin
        for (int unsigned s = 0; s < 2; s++) begin
            op[s] = rf[src[s]];
            if (ZERO_REG && src[s] == '0)
                op[s] = '0;
            if (wb_wr && wb_rd_q == src[s])
                op[s] = wb_wdata;
            if (ex_fwd && ex_rd == src[s])
                op[s] = ex_result;
        end
    end

    assign rs1_data = op[0];
    assign rs2_data = op[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_vld    <= 1'b0;
            ex_rd     <= '0;
            ex_wr     <= 1'b0;
            ex_load   <= 1'b0;
            wb_vld    <= 1'b0;
            wb_rd_q   <= '0;
            wb_wr_tag <= 1'b0;
            wb_load   <= 1'b0;
            wb_alu_q  <= '0;
        end else begin
            ex_vld    <= id_valid & !stall & !flush;
            ex_rd     <= id_rd;
            ex_wr     <= id_rd_wr;
            ex_load   <= id_is_load;
            wb_vld    <= ex_vld;
            wb_rd_q   <= ex_rd;
            wb_wr_tag <= ex_wr;
            wb_load   <= ex_load;
            wb_alu_q  <= ex_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++)
                rf[i] <= '0;
        end else if (wb_wr) begin
            rf[wb_rd_q] <= wb_wdata;
        end
    end

endmodule

// File: tb/tb_pl_bypass_regfile.sv
// Self-checking bench for pl_bypass_regfile: in-flight queue model plus directed literal checks.
module tb_pl_bypass_regfile;

    localparam int DW = 16;
    localparam int NR = 16;
    localparam int AW = 4;

`ifdef PL_BYPASS_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_rs1_used, id_rs2_used, id_rd_wr, id_is_load, flush;
    logic [DW-1:0] ex_result, dmem_rdata;
    logic [DW-1:0] rs1_data, rs2_data, wb_wdata;
    logic          stall, wb_wr;
    logic [AW-1:0] wb_rd;

    int errors = 0;
    int checks = 0;

    pl_bypass_regfile #(.DATA_W(DW), .NREG(NR)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_wr(id_rd_wr), .id_is_load(id_is_load),
        .flush(flush), .ex_result(ex_result), .dmem_rdata(dmem_rdata),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .stall(stall),
        .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_wdata(wb_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Accepted instructions still in flight; age 1 = one edge after acceptance, age 2 = two edges.
    typedef struct {
        logic [AW-1:0] rd;
        bit            wr;
        bit            ld;
        logic [DW-1:0] val;
        int            age;
    } ent_t;

    ent_t          inflight[$];
    ent_t          nq[$];
    ent_t          e;
    logic [DW-1:0] mrf [NR];

    function automatic bit writes(input logic [AW-1:0] rd, input bit wr);
        return wr && (!ZR || rd != '0);
    endfunction

    function automatic logic [DW-1:0] exp_op(input logic [AW-1:0] rs);
        foreach (inflight[i])
            if (inflight[i].age == 1 && writes(inflight[i].rd, inflight[i].wr)
                && !inflight[i].ld && inflight[i].rd == rs)
                return ex_result;
        foreach (inflight[i])
            if (inflight[i].age == 2 && writes(inflight[i].rd, inflight[i].wr)
                && inflight[i].rd == rs)
                return inflight[i].ld ? dmem_rdata : inflight[i].val;
        if (ZR && rs == '0)
            return '0;
        return mrf[rs];
    endfunction

    function automatic bit exp_stall();
        if (!id_valid || flush)
            return 1'b0;
        foreach (inflight[i])
            if (inflight[i].age == 1 && inflight[i].ld && writes(inflight[i].rd, inflight[i].wr))
                return (id_rs1_used && id_rs1 == inflight[i].rd)
                    || (id_rs2_used && id_rs2 == inflight[i].rd);
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight.delete();
            foreach (mrf[i]) mrf[i] = '0;
        end else begin
            nq.delete();
            foreach (inflight[i]) begin
                e = inflight[i];
                if (e.age == 1) begin
                    e.val = ex_result;
                    e.age = 2;
                    nq.push_back(e);
                end else if (writes(e.rd, e.wr)) begin
                    mrf[e.rd] = e.ld ? dmem_rdata : e.val;
                end
            end
            if (id_valid && !flush && !exp_stall()) begin
                e.rd  = id_rd;
                e.wr  = id_rd_wr;
                e.ld  = id_is_load;
                e.val = '0;
                e.age = 1;
                nq.push_back(e);
            end
            inflight = nq;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            bit            wexp;
            logic [AW-1:0] rexp;
            logic [DW-1:0] dexp;
            wexp = 1'b0;
            rexp = '0;
            dexp = '0;
            foreach (inflight[i])
                if (inflight[i].age == 2 && writes(inflight[i].rd, inflight[i].wr)) begin
                    wexp = 1'b1;
                    rexp = inflight[i].rd;
                    dexp = inflight[i].ld ? dmem_rdata : inflight[i].val;
                end
            check("model_rs1", rs1_data, exp_op(id_rs1));
            check("model_rs2", rs2_data, exp_op(id_rs2));
            check("model_stall", stall, exp_stall());
            check("model_wb_wr", wb_wr, wexp);
            if (wexp) begin
                check("model_wb_rd", wb_rd, rexp);
                check("model_wb_wdata", wb_wdata, dexp);
            end
        end
    end

    task automatic drive(input bit v, input logic [AW-1:0] r1, input bit u1,
                         input logic [AW-1:0] r2, input bit u2,
                         input logic [AW-1:0] rd, input bit wr, input bit ld, input bit fl,
                         input logic [DW-1:0] exr, input logic [DW-1:0] dmr);
        @(posedge clk);
        #1;
        id_valid    = v;
        id_rs1      = r1;
        id_rs1_used = u1;
        id_rs2      = r2;
        id_rs2_used = u2;
        id_rd       = rd;
        id_rd_wr    = wr;
        id_is_load  = ld;
        flush       = fl;
        ex_result   = exr;
        dmem_rdata  = dmr;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_rd_wr = 0; id_is_load = 0; flush = 0;
        ex_result = 0; dmem_rdata = 0;
        #3;
        check("reset_wb_wr", wb_wr, 0);
        check("reset_wb_rd", wb_rd, 0);
        check("reset_wb_wdata", wb_wdata, 0);
        check("reset_stall", stall, 0);
        check("reset_rs1", rs1_data, 0);
        #9 rst_n = 1'b1;

        for (int i = 0; i < NR; i++) begin
            drive(1, AW'(i), 1, AW'(NR - 1 - i), 1, 0, 0, 0, 0, 16'h0, 16'h0);
            check("empty_rs1", rs1_data, 0);
            check("empty_rs2", rs2_data, 0);
            check("empty_stall", stall, 0);
            check("empty_wb_wr", wb_wr, 0);
        end

        // EX then WB then RF path for r3
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 16'h0, 16'h0);
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 16'h1234, 16'h0);
        check("ex_fwd_rs1", rs1_data, 16'h1234);
        check("ex_fwd_stall", stall, 0);
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 16'hDEAD, 16'h0);
        check("wb_fwd_rs1", rs1_data, 16'h1234);
        check("wb_fwd_wb_rd", wb_rd, 3);
        drive(1, 0, 0, 3, 1, 0, 0, 0, 0, 16'h0, 16'h0);
        check("rf_r3", rs2_data, 16'h1234);
        idle(2);

        // load-use: one stall, then WB load data forwarded
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 16'h0, 16'h0);
        drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 16'h7777, 16'h0);
        check("lu_stall", stall, 1);
        drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 16'h0, 16'hBEEF);
        check("lu_stall_once", stall, 0);
        check("lu_rs2", rs2_data, 16'hBEEF);
        idle(2);

        // unused source never stalls
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 16'h0, 16'h0);
        drive(1, 0, 0, 5, 0, 0, 0, 0, 0, 16'h0, 16'h0);
        check("unused_no_stall", stall, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h5555);
        check("unused_wb_wdata", wb_wdata, 16'h5555);
        idle(2);

        // back-to-back writes to r7
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 16'h0, 16'h0);
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 16'h0001, 16'h0);
        drive(1, 7, 1, 0, 0, 0, 0, 0, 0, 16'h0002, 16'h0);
        check("b2b_youngest", rs1_data, 16'h0002);
        idle(1);
        drive(1, 7, 1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
        check("b2b_rf", rs1_data, 16'h0002);
        idle(2);

        // flush overrides load-use stall
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 16'h0, 16'h0);
        drive(1, 5, 1, 0, 0, 9, 1, 0, 1, 16'h0, 16'h0);
        check("flush_no_stall", stall, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'hCAFE);
        check("flush_load_wb", wb_wr, 1);
        idle(1);
        check("flush_bubble_wb", wb_wr, 0);
        idle(2);

        // register 0 write
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0, 16'h0);
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 16'hFFFF, 16'h0);
        check("r0_ex", rs1_data, ZR ? 16'h0 : 16'hFFFF);
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
        check("r0_wb_wr", wb_wr, ZR ? 0 : 1);
        check("r0_wb", rs1_data, ZR ? 16'h0 : 16'hFFFF);
        drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0, 16'h0);
        check("r0_rf", rs2_data, ZR ? 16'h0 : 16'hFFFF);
        idle(2);

        // reset mid-operation drops in-flight load and clears RF
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 16'h0, 16'h0);
        drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 16'h0, 16'h0);
        check("mid_pre_stall", stall, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_stall", stall, 0);
        check("mid_rst_wb_wr", wb_wr, 0);
        check("mid_rst_rs2", rs2_data, 0);
        id_valid = 0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        drive(1, 3, 1, 7, 1, 0, 0, 0, 0, 16'h0, 16'h0);
        check("mid_rst_r3", rs1_data, 0);
        check("mid_rst_r7", rs2_data, 0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: run exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
